conv_window_accumulator: RTL

Downstream stage of the 4-bit ALU in the convolution datapath. Consumes the 8-bit pixel×kernel products one tap per handshake and sums TAPS products into one convolution output pixel. Emits each window sum with a window index over a valid/ready handshake, and flags end of frame after NUM_WINDOWS outputs (4x4 image, 3x3 kernel → 2x2 output).

---
 rtl/conv_window_accumulator_pkg.sv | 24 ++
 rtl/conv_window_accumulator_if.sv | 30 +++
 rtl/conv_window_accumulator_sat_adder.sv | 29 ++
 rtl/conv_window_accumulator.sv | 121 ++++++++++++
 4 files changed

// File: rtl/conv_window_accumulator_pkg.sv
// Shared definitions for the convolution datapath: accumulator state encoding
// and the default frame geometry used by the sequencer, image memory and accumulator.
`timescale 1ns/1ps
package conv_window_accumulator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  // 4x4 image convolved with a 3x3 kernel gives a 2x2 output frame.
  localparam int DEF_TAPS        = 9;
  localparam int DEF_DATA_W      = 8;
  localparam int DEF_ACC_W       = 12;
  localparam int DEF_NUM_WINDOWS = 4;

  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_IDX_W = idx_width(DEF_NUM_WINDOWS);

endpackage

// File: rtl/conv_window_accumulator_if.sv
// Product-in / window-sum-out bus of the convolution accumulator.
`timescale 1ns/1ps
interface conv_window_accumulator_if #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 12,
    parameter int IDX_W  = 2
);
    // Both channels are valid/ready: a transfer happens on a rising edge where
    // valid and ready are both high; valid may not depend on ready, and the
    // accumulator's in_ready depends only on its state, never on in_valid.
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [ACC_W-1:0]  out_data;
    logic [IDX_W-1:0]  out_index;
    logic              out_ready;
    logic              frame_done;
    logic              overflow;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_index, frame_done, overflow
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_index, frame_done, overflow
    );
endinterface

// File: rtl/conv_window_accumulator_sat_adder.sv
// Combinational saturating adder: unsigned accumulator plus unsigned addend,
// clamped to all-ones with a saturation flag.
`timescale 1ns/1ps
module conv_sat_adder #(
    parameter int ACC_W  = 12,
    parameter int DATA_W = 8
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [DATA_W-1:0] addend,
    output logic [ACC_W-1:0]  sum,
    output logic              sat
);

    logic [ACC_W:0] wide;

    generate
        if (DATA_W > ACC_W) begin : g_bad_width
            $error("conv_sat_adder: DATA_W must not exceed ACC_W");
        end
    endgenerate

    // One extra bit is enough: the sum of two ACC_W-bit values cannot reach 2^(ACC_W+1).
    always_comb begin
        wide = {1'b0, acc} + (ACC_W + 1)'(addend);
        sat  = wide[ACC_W];
        sum  = sat ? '1 : wide[ACC_W-1:0];
    end

endmodule

// File: rtl/conv_window_accumulator.sv
// Sums TAPS pixel*kernel products per window and hands each window sum, tagged
// with its index, to the consumer; pulses frame_done on the last window of a frame.
`timescale 1ns/1ps
module conv_window_accumulator
    import conv_window_accumulator_pkg::*;
#(
    parameter int TAPS        = DEF_TAPS,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ACC_W       = DEF_ACC_W,
    parameter int NUM_WINDOWS = DEF_NUM_WINDOWS,
    parameter int IDX_W       = DEF_IDX_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    conv_window_accumulator_if.slave  bus,
    output state_t                    dbg_state
);

    localparam int                TAP_W    = $clog2(TAPS);
    localparam logic [TAP_W-1:0]  LAST_TAP = TAP_W'(TAPS - 1);
    localparam logic [IDX_W-1:0]  LAST_WIN = IDX_W'(NUM_WINDOWS - 1);

    generate
        if (TAPS < 2) begin : g_bad_taps
            $error("conv_window_accumulator: TAPS must be at least 2");
        end
        if (NUM_WINDOWS < 1) begin : g_bad_windows
            $error("conv_window_accumulator: NUM_WINDOWS must be at least 1");
        end
    endgenerate

    state_t            state;
    logic [ACC_W-1:0]  acc;
    logic [TAP_W-1:0]  tap_cnt;
    logic [IDX_W-1:0]  win_cnt;
    logic [ACC_W-1:0]  sum;
    logic              sat;
    logic              accept;

    assign bus.in_ready = (state != ST_HOLD);
    assign accept       = bus.in_valid & bus.in_ready;
    assign dbg_state    = state;

    // acc is zero whenever a window starts, so the same adder serves the first tap.
    conv_sat_adder #(
        .ACC_W  (ACC_W),
        .DATA_W (DATA_W)
    ) u_sat_adder (
        .acc    (acc),
        .addend (bus.in_data),
        .sum    (sum),
        .sat    (sat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            acc            <= '0;
            tap_cnt        <= '0;
            win_cnt        <= '0;
            bus.out_valid  <= 1'b0;
            bus.out_data   <= '0;
            bus.out_index  <= '0;
            bus.frame_done <= 1'b0;
            bus.overflow   <= 1'b0;
        end else if (clear) begin
            state          <= ST_IDLE;
            acc            <= '0;
            tap_cnt        <= '0;
            win_cnt        <= '0;
            bus.out_valid  <= 1'b0;
            bus.out_data   <= '0;
            bus.out_index  <= '0;
            bus.frame_done <= 1'b0;
            bus.overflow   <= 1'b0;
        end else begin
            bus.frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        acc          <= sum;
                        tap_cnt      <= TAP_W'(1);
                        bus.overflow <= bus.overflow | sat;
                        state        <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (accept) begin
                        bus.overflow <= bus.overflow | sat;
                        if (tap_cnt == LAST_TAP) begin
                            bus.out_data  <= sum;
                            bus.out_index <= win_cnt;
                            bus.out_valid <= 1'b1;
                            acc           <= '0;
                            tap_cnt       <= '0;
                            state         <= ST_HOLD;
                        end else begin
                            acc     <= sum;
                            tap_cnt <= tap_cnt + TAP_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        state         <= ST_IDLE;
                        if (win_cnt == LAST_WIN) begin
                            win_cnt        <= '0;
                            bus.frame_done <= 1'b1;
                        end else begin
                            win_cnt <= win_cnt + IDX_W'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
